// File: rtl/conv_layer2_sequencer_pkg.sv
// Shared definitions for the layer-2 convolution sequencer.
// Contents: the FSM state type, a constant clog2 helper, and the helpers that
// derive the output side length and the buffer address widths.
package conv_layer2_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_STREAM = 3'd2,
    ST_FLUSH  = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_NEXT   = 3'd5,
    ST_DONE   = 3'd6
  } state_t;

  // Number of bits needed to hold value-1; for example, clog2(144) is 8.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 32'sd0;
    v      = value - 32'sd1;
    while (v > 32'sd0) begin
      result = result + 32'sd1;
      v      = v >>> 1;
    end
    return result;
  endfunction

  function automatic int calc_o_size(input int i_size, input int k_size);
    return i_size - k_size + 32'sd1;
  endfunction

  function automatic int calc_aw_in(input int i_size);
    return clog2(i_size * i_size);
  endfunction

  function automatic int calc_aw_out(input int co, input int i_size, input int k_size);
    int o;
    o = calc_o_size(i_size, k_size);
    return clog2(co * o * o);
  endfunction

endpackage

// File: rtl/conv_layer2_sequencer_if.sv
// Bus between the sequencer and its neighbours. The bus carries these signals:
//   fmap_rd/fmap_addr        : synchronous-read input buffer request
//   conv_ce/self_rst/user_reset : engine controls
//   conv_valid/conv_end/conv_all_end : engine status
//   wr_en/wr_addr            : output buffer write port
// The master modport is the sequencer. The slave modport is the engine and buffer side.
interface conv_layer2_sequencer_if #(
  parameter int AW_IN  = 8,
  parameter int AW_OUT = 8
) ();
  logic              fmap_rd;
  logic [AW_IN-1:0]  fmap_addr;
  logic              conv_ce;
  logic              self_rst;
  logic              user_reset;
  logic              conv_valid;
  logic              conv_end;
  logic              conv_all_end;
  logic              wr_en;
  logic [AW_OUT-1:0] wr_addr;

  modport master (
    output fmap_rd, fmap_addr, conv_ce, self_rst, user_reset, wr_en, wr_addr,
    input  conv_valid, conv_end, conv_all_end
  );

  modport slave (
    input  fmap_rd, fmap_addr, conv_ce, self_rst, user_reset, wr_en, wr_addr,
    output conv_valid, conv_end, conv_all_end
  );
endinterface

// File: rtl/conv_layer2_sequencer_out_addr_gen.sv
// This module holds the output channel counter and the per-channel result counter.
// It forms the linear output-buffer address as ch*O_SIZE^2 + outcnt.
// Ports:
//   i_clr_all   : start of a run; channel and result count go to 0
//   i_chan_done : end of a channel; result count goes to 0 and the channel advances unless it is last
//   i_count_en  : results are accepted only while this input is high
//   i_valid     : engine result valid
//   o_ch, o_last_ch, o_full : counter state
//   o_wr_en, o_wr_addr      : same-cycle write strobe and address (address is 0 when there is no write)
//   o_ovf       : a result arrived after the channel already had O_SIZE^2 results
module conv_out_addr_gen
  import conv_layer2_sequencer_pkg::*;
#(
  parameter int CO     = 4,
  parameter int O_SIZE = 8,
  parameter int AW_OUT = 8,
  parameter int CH_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr_all,
  input  logic              i_chan_done,
  input  logic              i_count_en,
  input  logic              i_valid,
  output logic [CH_W-1:0]   o_ch,
  output logic              o_last_ch,
  output logic              o_full,
  output logic              o_wr_en,
  output logic [AW_OUT-1:0] o_wr_addr,
  output logic              o_ovf
);
  localparam int O_SQ  = O_SIZE * O_SIZE;
  localparam int CNT_W = clog2(O_SQ + 1);

  logic [CH_W-1:0]  r_ch;
  logic [CNT_W-1:0] r_outcnt;
  logic             w_full;
  logic             w_wr_en;

  assign w_full  = (r_outcnt == CNT_W'(O_SQ));
  assign w_wr_en = i_count_en & i_valid & ~w_full;

  assign o_ch      = r_ch;
  assign o_last_ch = (r_ch == CH_W'(CO - 1));
  assign o_full    = w_full;
  assign o_wr_en   = w_wr_en;
  assign o_ovf     = i_count_en & i_valid & w_full;
  assign o_wr_addr = w_wr_en ? (AW_OUT'(r_ch) * AW_OUT'(O_SQ) + AW_OUT'(r_outcnt))
                             : {AW_OUT{1'b0}};

  // Channel and result counters. A result in the channel-done cycle is still written, and then the count restarts.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ch     <= {CH_W{1'b0}};
      r_outcnt <= {CNT_W{1'b0}};
    end else if (i_clr_all) begin
      r_ch     <= {CH_W{1'b0}};
      r_outcnt <= {CNT_W{1'b0}};
    end else if (i_chan_done) begin
      r_ch     <= o_last_ch ? r_ch : r_ch + CH_W'(1'b1);
      r_outcnt <= {CNT_W{1'b0}};
    end else if (w_wr_en) begin
      r_ch     <= r_ch;
      r_outcnt <= r_outcnt + CNT_W'(1'b1);
    end else begin
      r_ch     <= r_ch;
      r_outcnt <= r_outcnt;
    end
  end
endmodule

// File: rtl/conv_layer2_sequencer.sv
// Sequencer for the layer-2 5x5 convolution engine.
// For each of the CO output channels, it streams the I_SIZE^2 input map into the engine.
// It then issues FLUSH extra ce cycles, waits for the engine to finish the channel, and pulses self_rst.
// One user_reset pulse opens each run.
// Ports: clk, rst (synchronous, active-high), i_start, i_pause (stalls reads and flush ce),
//        bus (master side of conv_layer2_sequencer_if), o_ch, o_busy, o_done, o_err.
// o_err is the sticky flag. In the DONE cycle it also shows a missing conv_all_end
// combinationally, because the engine's channel count only settles in that cycle.
module conv_layer2_sequencer
  import conv_layer2_sequencer_pkg::*;
#(
  parameter  int I_SIZE = 12,
  parameter  int K_SIZE = 5,
  parameter  int CO     = 4,
  parameter  int FLUSH  = 2,
  localparam int O_SIZE = calc_o_size(I_SIZE, K_SIZE),
  localparam int AW_IN  = calc_aw_in(I_SIZE),
  localparam int AW_OUT = calc_aw_out(CO, I_SIZE, K_SIZE),
  localparam int CH_W   = clog2(CO) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_start,
  input  logic                   i_pause,
  conv_layer2_sequencer_if.master bus,
  output logic [CH_W-1:0]        o_ch,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_err
);
  localparam int FL_W = clog2(FLUSH) + 1;
  localparam int TMO  = 4 * I_SIZE;
  localparam int DR_W = clog2(TMO) + 1;
  localparam logic [AW_IN-1:0] PIX_LAST = AW_IN'(I_SIZE * I_SIZE - 1);

  state_t            r_state, w_next_state;
  logic [AW_IN-1:0]  r_pix;
  logic [FL_W-1:0]   r_flush_cnt;
  logic [DR_W-1:0]   r_drain_cnt;
  logic              r_ce, r_end_seen, r_err;
  logic              w_rd, w_ce_req, w_user_reset, w_self_rst, w_done;
  logic              w_count_en, w_err_set, w_done_err, w_end;
  logic              w_last_ch, w_full, w_ovf, w_wr_en;
  logic [AW_OUT-1:0] w_wr_addr;

  conv_out_addr_gen #(.CO(CO), .O_SIZE(O_SIZE), .AW_OUT(AW_OUT), .CH_W(CH_W)) u_addr_gen (
    .clk         (clk),
    .rst         (rst),
    .i_clr_all   (w_user_reset),
    .i_chan_done (w_self_rst),
    .i_count_en  (w_count_en),
    .i_valid     (bus.conv_valid),
    .o_ch        (o_ch),
    .o_last_ch   (w_last_ch),
    .o_full      (w_full),
    .o_wr_en     (w_wr_en),
    .o_wr_addr   (w_wr_addr),
    .o_ovf       (w_ovf)
  );

  // A conv_end seen earlier in the channel counts the same as one seen now.
  assign w_end = r_end_seen | bus.conv_end;

  // Next-state and per-state strobes.
  always_comb begin
    w_next_state = r_state;
    w_rd         = 1'b0;
    w_ce_req     = 1'b0;
    w_user_reset = 1'b0;
    w_self_rst   = 1'b0;
    w_done       = 1'b0;
    w_count_en   = 1'b0;
    w_err_set    = 1'b0;
    w_done_err   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) w_next_state = ST_CLEAR;
        else         w_next_state = ST_IDLE;
      end
      ST_CLEAR: begin
        w_user_reset = 1'b1;
        w_next_state = ST_STREAM;
      end
      ST_STREAM: begin
        w_count_en = 1'b1;
        if (!i_pause) begin
          w_rd     = 1'b1;
          w_ce_req = 1'b1;
          if (r_pix == PIX_LAST) w_next_state = ST_FLUSH;
          else                   w_next_state = ST_STREAM;
        end else begin
          w_next_state = ST_STREAM;
        end
      end
      ST_FLUSH: begin
        w_count_en = 1'b1;
        if (!i_pause) begin
          w_ce_req = 1'b1;
          if (r_flush_cnt == FL_W'(FLUSH - 1)) w_next_state = ST_DRAIN;
          else                                 w_next_state = ST_FLUSH;
        end else begin
          w_next_state = ST_FLUSH;
        end
      end
      ST_DRAIN: begin
        w_count_en = 1'b1;
        if (w_end) begin
          w_err_set    = ~w_full;
          w_next_state = ST_NEXT;
        end else if (r_drain_cnt == DR_W'(TMO - 1)) begin
          w_err_set    = 1'b1;
          w_next_state = ST_NEXT;
        end else begin
          w_next_state = ST_DRAIN;
        end
      end
      ST_NEXT: begin
        w_count_en = 1'b1;
        w_self_rst = 1'b1;
        if (w_last_ch) w_next_state = ST_DONE;
        else           w_next_state = ST_STREAM;
      end
      ST_DONE: begin
        w_done       = 1'b1;
        w_done_err   = ~bus.conv_all_end;
        w_err_set    = w_done_err;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // This block holds the read address, the ce pipeline, the flush and drain counters, the sticky end flag, and the error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pix       <= {AW_IN{1'b0}};
      r_ce        <= 1'b0;
      r_flush_cnt <= {FL_W{1'b0}};
      r_drain_cnt <= {DR_W{1'b0}};
      r_end_seen  <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      // ce trails its request by one cycle so it lines up with the buffer's read data.
      r_ce <= w_ce_req;
      if (w_rd)                                            r_pix <= (r_pix == PIX_LAST) ? {AW_IN{1'b0}} : r_pix + AW_IN'(1'b1);
      else if (r_state == ST_CLEAR || r_state == ST_NEXT) r_pix <= {AW_IN{1'b0}};
      else                                                r_pix <= r_pix;
      if (r_state != ST_FLUSH) r_flush_cnt <= {FL_W{1'b0}};
      else if (!i_pause)       r_flush_cnt <= r_flush_cnt + FL_W'(1'b1);
      else                     r_flush_cnt <= r_flush_cnt;
      if (r_state == ST_DRAIN) r_drain_cnt <= r_drain_cnt + DR_W'(1'b1);
      else                     r_drain_cnt <= {DR_W{1'b0}};
      if (r_state == ST_CLEAR || r_state == ST_NEXT) r_end_seen <= 1'b0;
      else if (w_count_en && bus.conv_end)           r_end_seen <= 1'b1;
      else                                           r_end_seen <= r_end_seen;
      if (r_state == ST_IDLE && i_start) r_err <= 1'b0;
      else if (w_err_set || w_ovf)       r_err <= 1'b1;
      else                               r_err <= r_err;
    end
  end

  assign bus.fmap_rd    = w_rd;
  assign bus.fmap_addr  = r_pix;
  assign bus.conv_ce    = r_ce;
  assign bus.self_rst   = w_self_rst;
  assign bus.user_reset = w_user_reset;
  assign bus.wr_en      = w_wr_en;
  assign bus.wr_addr    = w_wr_addr;
  assign o_busy         = (r_state != ST_IDLE);
  assign o_done         = w_done;
  assign o_err          = r_err | w_done_err;
endmodule

// File: doc/conv_layer2_sequencer.md
Name: conv_layer2_sequencer

Overview:
- Controls one 5x5 layer-2 convolution engine, which has a single MAC chain and processes one output channel at a time.
- Streams the I_SIZE x I_SIZE input feature map from a synchronous-read buffer into the engine's ce/fmap port once per output channel.
- Issues the per-channel self_rst and per-run user_reset pulses, and writes every valid result to a linear output buffer.
- Sits between the layer-1 pooling buffer and the layer-2 pooling stage, under control of the top-level layer FSM.

Parameters:
- I_SIZE, 12, input feature-map side length.
- K_SIZE, 5, kernel side length.
- CO, 4, number of output channels.
- FLUSH, 2, extra ce cycles after the last pixel. The engine's conv_end needs its ce count to reach I_SIZE*I_SIZE+2.
- O_SIZE, I_SIZE-K_SIZE+1 (derived, 8), output side length.
- AW_IN, clog2(I_SIZE*I_SIZE), input address width.
- AW_OUT, clog2(CO*O_SIZE*O_SIZE), output address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- i_start  in  1  one-cycle start pulse; ignored unless in IDLE
- i_pause  in  1  stall; blocks new fmap reads while high
- o_fmap_rd  out  1  input buffer read enable; data is returned the next cycle
- o_fmap_addr  out  AW_IN  input buffer read address
- o_conv_ce  out  1  engine clock enable
- o_self_rst  out  1  engine per-channel clear; engine channel counter increments
- o_user_reset  out  1  engine full clear; engine channel counter goes to 0
- i_conv_valid  in  1  engine result valid
- i_conv_end  in  1  engine channel finished
- i_conv_all_end  in  1  engine reports all CO channels done
- o_wr_en  out  1  output buffer write strobe
- o_wr_addr  out  AW_OUT  output buffer write address
- o_ch  out  clog2(CO)+1  current output channel
- o_busy  out  1  high in any state except IDLE
- o_done  out  1  one-cycle pulse at end of run
- o_err  out  1  sticky protocol-error flag

Behaviour:
- Reset (rst=1 at a clock edge):
  - State goes to IDLE; every output goes to 0, including o_err and o_ch.
  - This applies mid-run too: the run is abandoned and o_user_reset is not pulsed.
  - The engine receives rst on its own path.
- States: IDLE, CLEAR, STREAM, FLUSH, DRAIN, NEXT, DONE.
- IDLE:
  - i_start moves to CLEAR and clears o_err.
  - i_start in any other state is ignored.
- CLEAR: o_user_reset=1 for exactly one cycle; o_ch=0, pix=0, outcnt=0. Next state is STREAM.
- STREAM:
  - Each cycle with i_pause=0: o_fmap_rd=1 with o_fmap_addr=pix, then pix increments.
  - With i_pause=1: o_fmap_rd=0 and the address holds.
  - o_conv_ce is o_fmap_rd registered by one cycle. ce is therefore aligned with the returned data, and pause takes effect on ce one cycle late.
  - After the read at pix=I_SIZE*I_SIZE-1, go to FLUSH.
- FLUSH:
  - Issues FLUSH ce cycles with o_fmap_rd=0; fmap data is don't-care.
  - i_pause also stalls the flush. The count is ce cycles, not clock cycles.
  - Next state is DRAIN.
- Result counting (any state, from CLEAR exit until NEXT):
  - Each cycle with i_conv_valid=1 and outcnt<O_SIZE^2: o_wr_en=1 and o_wr_addr=o_ch*O_SIZE^2+outcnt, combinational in the same cycle; then outcnt increments.
  - i_conv_valid=1 with outcnt==O_SIZE^2 sets o_err and writes nothing.
- DRAIN:
  - Waits until i_conv_end has been seen (sticky since CLEAR/NEXT) and outcnt==O_SIZE^2.
  - If i_conv_end is seen with outcnt<O_SIZE^2, set o_err and proceed anyway.
  - Timeout: 4*I_SIZE cycles in DRAIN also sets o_err and proceeds.
- NEXT:
  - o_self_rst=1 for one cycle; pix=0, outcnt=0, sticky end is cleared.
  - If o_ch==CO-1, go to DONE. Otherwise o_ch increments and the state goes to STREAM.
- DONE:
  - o_done=1 for one cycle, then IDLE; o_ch holds CO-1.
  - If i_conv_all_end is not 1 in this cycle, set o_err. The engine counter reaches CO one cycle after the last self_rst.
- Simultaneous events:
  - i_conv_valid is still counted in the NEXT cycle that samples it.
  - i_pause during CLEAR, NEXT or DONE has no effect.

Decomposition:
- Shared header (alongside the existing clog2 function include): state encoding localparams, the clog2 function, and the derived O_SIZE/AW_* expressions.
- One sub-module, conv_out_addr_gen: the channel/outcnt counters and the write-address multiply-add with overflow error detection.
- The FSM, read-address counter and ce pipeline stay in the top module.

Test Plan:
- Nominal run, I_SIZE=12, CO=4, engine model emitting 64 valids per channel:
  - exactly 144 rd per channel (addr 0..143) and 146 ce per channel;
  - 4 self_rst pulses and 1 user_reset;
  - 256 writes at addresses 0..255 in order;
  - o_done a single pulse and o_err=0.
- i_pause held high for 7 cycles at pix=50:
  - rd low for exactly those 7 cycles and ce low for 7 cycles starting one cycle later;
  - addresses continue at 50 with no skip or duplicate;
  - total ce per channel is still 146.
- Engine model emits a 65th valid in channel 1:
  - o_err=1 with no write for that valid;
  - channel-1 writes cover exactly 64..127.
- rst asserted during channel 2 STREAM at pix=30:
  - next cycle all outputs are 0 and the state is IDLE;
  - a new i_start yields a clean run from ch0/addr0 with user_reset pulsed.
- i_conv_end never asserted in channel 0: o_err sets after 48 DRAIN cycles and the run proceeds to channel 1.
- i_start pulsed mid-run, and i_conv_all_end forced 0 at DONE:
  - the mid-run start is ignored, with no extra user_reset;
  - o_err=1 at the o_done cycle.
